seq_matcher: RTL

Programmable, parametrised sequence detector for symbol streams. It compares the most recent N input symbols against a run-time-loaded pattern of length 1..MAX_LEN, with selectable overlapping or non-overlapping match modes. It produces a registered one-cycle match pulse and a saturating match counter. It replaces fixed-pattern, hard-coded FSM detectors in the data path and sits directly on a symbol stream qualified by a valid strobe.

---
 rtl/seq_matcher.sv | 68 ++++++
 1 files changed

// File: rtl/seq_matcher.sv
// seq_matcher: programmable sequence detector with overlap control, match pulse and saturating counter
module seq_matcher #(
    parameter int SYM_W   = 3,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [SYM_W-1:0]             data,
    input  logic                         data_valid,
    input  logic                         cfg_wr,
    input  logic [$clog2(MAX_LEN)-1:0]   cfg_idx,
    input  logic [SYM_W-1:0]             cfg_sym,
    input  logic                         cfg_len_wr,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         overlap,
    input  logic                         clr_count,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic [SYM_W-1:0] pattern [MAX_LEN];
    logic [SYM_W-1:0] hist [MAX_LEN-1];
    logic [LW-1:0]    len;
    logic [LW-1:0]    last;
    logic [IW-1:0]    fill;
    logic             cfg_any, accept, len_ok, hist_ok, hit;

    // hist[k] lines up with pattern[len-2-k]; slots beyond the pattern are don't-care
    always_comb begin
        cfg_any = cfg_wr | cfg_len_wr;
        accept  = data_valid & ~cfg_any;
        len_ok  = len != '0 && int'(len) <= MAX_LEN;
        last    = len - LW'(1);
        hist_ok = 1'b1;
        for (int k = 0; k < MAX_LEN - 1; k++)
            if (k <= int'(len) - 2 && hist[k] != pattern[IW'(int'(len) - 2 - k)])
                hist_ok = 1'b0;
        hit = accept && len_ok && int'(fill) >= int'(len) - 1 &&
              data == pattern[last[IW-1:0]] && hist_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) pattern[i] <= '0;
            for (int i = 0; i < MAX_LEN - 1; i++) hist[i] <= '0;
            len         <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            if (cfg_wr && int'(cfg_idx) < MAX_LEN) pattern[cfg_idx] <= cfg_sym;
            if (cfg_len_wr) len <= cfg_len;
            if (accept) begin
                hist[0] <= data;
                for (int i = 1; i < MAX_LEN - 1; i++) hist[i] <= hist[i-1];
            end
            // non-overlap restarts the fill so the matching symbol cannot seed the next hit
            fill <= (cfg_any || (hit && !overlap)) ? '0 :
                    (accept && fill != IW'(MAX_LEN - 1)) ? fill + 1'b1 : fill;
            match       <= hit;
            match_count <= clr_count ? CNT_W'(hit) :
                           (hit && !(&match_count)) ? match_count + 1'b1 : match_count;
        end
    end
endmodule
